misr_sig_checker: RTL and testbench

- Response-side counterpart of the LBIST pattern LFSR. It compacts per-pattern CUT response vectors into a multiple-input signature register (MISR).
- After a programmed number of patterns it compares the final signature with a golden value and reports pass/fail.
- Sits between the scan/CUT response outputs and the LBIST controller.

---
 rtl/bist_pkg.sv | 15 +
 rtl/misr_core.sv | 34 +++
 rtl/misr_sig_checker.sv | 104 ++++++++++
 tb/tb_misr_sig_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared LBIST types and constants.
// Used by the MISR signature checker and its core.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        COMPARE,
        DONE
    } misr_state_t;

    localparam logic [63:0] DEFAULT_MISR_TAPS = 64'hC000_0000_0000_2011;
    localparam logic [63:0] DEFAULT_SEED      = 64'h0;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift right,
// feedback into the MSB, response XORed in.
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_MISR_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] signature
);

    logic             fb;
    logic [WIDTH-1:0] sig_nxt;

    always_comb begin
        fb      = ^(signature & TAPS);
        sig_nxt = {fb, signature[WIDTH-1:1]} ^ data;
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            signature <= SEED;
        end else if (en) begin
            signature <= sig_nxt;
        end
    end

endmodule

// File: rtl/misr_sig_checker.sv
// Compacts PATTERNS response vectors into a MISR and
// compares the final signature against a golden value.
module misr_sig_checker
    import bist_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_MISR_TAPS),
    parameter int               PATTERNS = 1024,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);

    misr_state_t state_q, state_d;
    logic        load;
    logic        en;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        en      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = COMPACT;
                end
            end
            COMPACT: begin
                busy = 1'b1;
                en   = resp_valid;
                if (resp_valid && count == LAST) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = COMPACT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving COMPACT on the last vector is what keeps count from wrapping.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            pass <= 1'b0;
        end else if (state_q == COMPARE) begin
            pass <= (signature == golden);
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .en        (en),
        .data      (resp_data),
        .signature (signature)
    );

endmodule

// File: tb/tb_misr_sig_checker.sv
// Directed bench for misr_sig_checker using three
// instances with PATTERNS of 1, 2 and 4.
module tb_misr_sig_checker;

    localparam logic [63:0] TOP = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C3  = 64'hC000_0000_0000_0000;
    localparam logic [63:0] G4  = 64'h6000_0000_0000_00F0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_data = '0;
    logic [63:0] golden = '0;

    logic        busy1, done1, pass1;
    logic        busy2, done2, pass2;
    logic        busy4, done4, pass4;
    logic [63:0] sig1, sig2, sig4;
    logic [15:0] cnt1, cnt2, cnt4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    misr_sig_checker #(.PATTERNS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .golden(golden), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1), .count(cnt1)
    );

    misr_sig_checker #(.PATTERNS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .golden(golden), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2), .count(cnt2)
    );

    misr_sig_checker #(.PATTERNS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .golden(golden), .busy(busy4), .done(done4),
        .pass(pass4), .signature(sig4), .count(cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        step();
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (busy4 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy4); else passed++;
        total++; if (done4 !== 1'b0) $display("FAIL rst_done got %b want 0", done4); else passed++;
        total++; if (pass4 !== 1'b0) $display("FAIL rst_pass got %b want 0", pass4); else passed++;
        total++; if (sig4 !== 64'h0) $display("FAIL rst_sig got %h want 0", sig4); else passed++;
        total++; if (cnt4 !== 16'd0) $display("FAIL rst_cnt got %0d want 0", cnt4); else passed++;
        total++; if (done1 !== 1'b0) $display("FAIL rst_done1 got %b want 0", done1); else passed++;
    endtask

    task automatic test_single();
        golden = 64'h1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        total++; if (busy1 !== 1'b1) $display("FAIL single_busy got %b want 1", busy1); else passed++;
        send(64'h1);
        total++; if (sig1 !== 64'h1) $display("FAIL single_sig got %h want 1", sig1); else passed++;
        total++; if (done1 !== 1'b0) $display("FAIL single_cmp_done got %b want 0", done1); else passed++;
        step();
        total++; if (done1 !== 1'b1) $display("FAIL single_done got %b want 1", done1); else passed++;
        total++; if (pass1 !== 1'b1) $display("FAIL single_pass got %b want 1", pass1); else passed++;
        total++; if (cnt1 !== 16'd1) $display("FAIL single_cnt got %0d want 1", cnt1); else passed++;
    endtask

    task automatic test_feedback();
        golden = TOP;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        send(64'h1);
        total++; if (sig2 !== 64'h1) $display("FAIL fb_sig1 got %h want 1", sig2); else passed++;
        send(64'h0);
        total++; if (sig2 !== TOP) $display("FAIL fb_sig2 got %h want %h", sig2, TOP); else passed++;
        total++; if (cnt2 !== 16'd2) $display("FAIL fb_cnt got %0d want 2", cnt2); else passed++;
        step();
        total++; if (done2 !== 1'b1) $display("FAIL fb_done got %b want 1", done2); else passed++;
        total++; if (pass2 !== 1'b1) $display("FAIL fb_pass got %b want 1", pass2); else passed++;
    endtask

    task automatic test_mismatch();
        golden = 64'h0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        total++; if (done2 !== 1'b0) $display("FAIL mm_restart_done got %b want 0", done2); else passed++;
        send(64'h1);
        send(64'h0);
        step();
        total++; if (done2 !== 1'b1) $display("FAIL mm_done got %b want 1", done2); else passed++;
        total++; if (pass2 !== 1'b0) $display("FAIL mm_pass got %b want 0", pass2); else passed++;
        total++; if (sig2 !== TOP) $display("FAIL mm_sig got %h want %h", sig2, TOP); else passed++;
    endtask

    task automatic test_gaps();
        golden = G4;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        send(64'h1);
        send(64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (cnt4 !== 16'd2 || sig4 !== TOP)
                $display("FAIL gap_hold%0d got %0d/%h want 2/%h", i, cnt4, sig4, TOP);
            else passed++;
        end
        send(64'h0);
        step();
        total++; if (cnt4 !== 16'd3 || sig4 !== C3)
            $display("FAIL gap_hold3 got %0d/%h want 3/%h", cnt4, sig4, C3);
        else passed++;
        send(64'hF0);
        total++; if (cnt4 !== 16'd4) $display("FAIL gap_cnt got %0d want 4", cnt4); else passed++;
        step();
        total++; if (sig4 !== G4) $display("FAIL gap_sig got %h want %h", sig4, G4); else passed++;
        total++; if (done4 !== 1'b1 || pass4 !== 1'b1)
            $display("FAIL gap_result got done=%b pass=%b want 1/1", done4, pass4);
        else passed++;
    endtask

    task automatic test_reset_mid();
        golden = G4;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        send(64'h1);
        send(64'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (busy4 !== 1'b0 || done4 !== 1'b0)
            $display("FAIL mid_flags got busy=%b done=%b want 0/0", busy4, done4);
        else passed++;
        total++; if (sig4 !== 64'h0 || cnt4 !== 16'd0)
            $display("FAIL mid_regs got %h/%0d want 0/0", sig4, cnt4);
        else passed++;
        send(64'h5);
        total++; if (sig4 !== 64'h0 || cnt4 !== 16'd0 || busy4 !== 1'b0)
            $display("FAIL idle_ignore got %h/%0d/%b want 0/0/0", sig4, cnt4, busy4);
        else passed++;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        send(64'h1);
        send(64'h0);
        send(64'h0);
        send(64'hF0);
        step();
        total++; if (done4 !== 1'b1 || pass4 !== 1'b1 || sig4 !== G4)
            $display("FAIL mid_rerun got %b/%b/%h want 1/1/%h", done4, pass4, sig4, G4);
        else passed++;
    endtask

    task automatic test_start();
        golden = G4;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        send(64'h1);
        start4 = 1'b1;
        send(64'h0);
        start4 = 1'b0;
        total++; if (cnt4 !== 16'd2 || sig4 !== TOP)
            $display("FAIL start_ignored got %0d/%h want 2/%h", cnt4, sig4, TOP);
        else passed++;
        send(64'h0);
        send(64'hF0);
        step();
        total++; if (done4 !== 1'b1 || pass4 !== 1'b1)
            $display("FAIL start_s1 got done=%b pass=%b want 1/1", done4, pass4);
        else passed++;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        total++; if (done4 !== 1'b0 || busy4 !== 1'b1 || pass4 !== 1'b0)
            $display("FAIL start_reseed got d=%b b=%b p=%b want 0/1/0", done4, busy4, pass4);
        else passed++;
        total++; if (sig4 !== 64'h0 || cnt4 !== 16'd0)
            $display("FAIL start_regs got %h/%0d want 0/0", sig4, cnt4);
        else passed++;
        send(64'h1);
        send(64'h0);
        send(64'h0);
        send(64'hF0);
        step();
        total++; if (sig4 !== G4 || pass4 !== 1'b1)
            $display("FAIL start_s2 got %h/%b want %h/1", sig4, pass4, G4);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        test_reset();
        test_single();
        test_feedback();
        test_mismatch();
        test_gaps();
        test_reset_mid();
        test_start();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
